// File: rtl/state_unpack_cit__unpack_poly_group.sv
// rtl/state_unpack_cit__unpack_poly_group.sv - serial 3-bit ciphertext group unpacker/decompressor
//
// Purpose: takes one packed 24-bit ciphertext group (8 x 3-bit compressed
// coefficients), then decompresses one coefficient per clock through a single
// shared multiply/round datapath, x = (t*KYBER_Q + 4) >> 3. All eight results
// are published together on oCoeffs with a one-cycle done pulse.
//
// Ports:
//   clk                input   system clock, rising edge
//   reset_n            input   asynchronous active-low reset
//   enable             input   start request, only honoured while idle
//   iCiphertext_Group  input   [23:16]=byte0, [15:8]=byte1, [7:0]=byte2
//   busy               output  high while a group is being unpacked
//   Unpack_Group_done  output  one-cycle pulse, oCoeffs valid from this cycle
//   oCoeffs            output  [95:84]=coeff0 ... [11:0]=coeff7

// Decompression of a single 3-bit coefficient.
// Ports: t_i (compressed value), x_o (coefficient in Z_q, always < KYBER_Q).
module state_unpack_cit__decompress3 #(
    parameter int KYBER_Q = 3329
) (
    input  logic [2:0]  t_i,
    output logic [11:0] x_o
);
    // Max t*Q + 4 = 7*3329 + 4 = 23307, so 15 bits hold the full sum.
    logic [14:0] prod;
    logic [14:0] rounded;

    assign prod    = {12'd0, t_i} * 15'(KYBER_Q);
    assign rounded = prod + 15'd4;
    assign x_o     = rounded[14:3];
endmodule

module state_unpack_cit__unpack_poly_group #(
    parameter int KYBER_Q            = 3329,
    parameter int Compress_Bits      = 3,
    parameter int i_Ciphertext_Width = 24,
    parameter int o_Coeffs_Width     = 12,
    parameter int Coeffs_Per_Group   = 8
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       enable,
    input  logic [i_Ciphertext_Width-1:0]              iCiphertext_Group,
    output logic                                       busy,
    output logic                                       Unpack_Group_done,
    output logic [Coeffs_Per_Group*o_Coeffs_Width-1:0] oCoeffs
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNPACK = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(Coeffs_Per_Group - 1);

    state_t                                     state_q;
    logic [i_Ciphertext_Width-1:0]              grp_q;
    logic [2:0]                                 idx_q;
    logic [2:0]                                 idx_d;
    logic                                       busy_q;
    logic                                       done_q;
    logic [o_Coeffs_Width-1:0]                  coef_q [Coeffs_Per_Group];
    logic [Coeffs_Per_Group*o_Coeffs_Width-1:0] coeffs_q;
    logic [Coeffs_Per_Group*o_Coeffs_Width-1:0] coeffs_d;
    logic [i_Ciphertext_Width-1:0]              stream_d;
    logic [Compress_Bits-1:0]                   t_cur;
    logic [11:0]                                x_cur;

    // Little-endian bitstream: byte0 occupies the low bits, so coefficient j
    // is simply stream[3j+2:3j]. Reordering happens once, at latch time.
    assign stream_d = {iCiphertext_Group[7:0],
                       iCiphertext_Group[15:8],
                       iCiphertext_Group[23:16]};

    assign t_cur = grp_q[Compress_Bits*idx_q +: Compress_Bits];
    assign idx_d = idx_q + 3'd1;

    state_unpack_cit__decompress3 #(
        .KYBER_Q (KYBER_Q)
    ) u_decompress (
        .t_i (t_cur),
        .x_o (x_cur)
    );

    // coeff0 lands in the most significant slot of the output word.
    always_comb begin
        coeffs_d = '0;
        for (int i = 0; i < Coeffs_Per_Group; i++) begin
            coeffs_d[(Coeffs_Per_Group-1-i)*o_Coeffs_Width +: o_Coeffs_Width] = coef_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grp_q    <= '0;
            idx_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            coeffs_q <= '0;
            for (int i = 0; i < Coeffs_Per_Group; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        grp_q   <= stream_d;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    coef_q[idx_q] <= x_cur;
                    idx_q         <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // Only point where oCoeffs changes, so partial groups never leak out.
                    coeffs_q <= coeffs_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    idx_q    <= 3'd0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    idx_q   <= 3'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy              = busy_q;
    assign Unpack_Group_done = done_q;
    assign oCoeffs           = coeffs_q;
endmodule

// File: tb/tb_state_unpack_cit__unpack_poly_group.sv
// tb/tb_state_unpack_cit__unpack_poly_group.sv - randomized self-checking bench for the group unpacker
module tb_state_unpack_cit__unpack_poly_group;
    localparam int Q = 3329;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [23:0] iCiphertext_Group;
    logic        busy;
    logic        Unpack_Group_done;
    logic [95:0] oCoeffs;

    int n_vec;
    int n_err;

    state_unpack_cit__unpack_poly_group dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .iCiphertext_Group (iCiphertext_Group),
        .busy              (busy),
        .Unpack_Group_done (Unpack_Group_done),
        .oCoeffs           (oCoeffs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bytes -> integer bitstream -> 3-bit fields -> rounded t*Q/8.
    function automatic int ref_coeff(input logic [23:0] g, input int j);
        int s;
        int t;
        s = int'(g[23:16]) + int'(g[15:8]) * 256 + int'(g[7:0]) * 65536;
        t = (s / (1 << (3 * j))) % 8;
        return (t * Q + 4) / 8;
    endfunction

    function automatic logic [95:0] ref_group(input logic [23:0] g);
        logic [95:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[95 - 12*j -: 12] = 12'(ref_coeff(g, j));
        end
        return r;
    endfunction

    // Encapsulation-side packer: compress to 3 bits then pack little-endian.
    function automatic logic [23:0] pack_group(input int c [8]);
        int s;
        int t;
        logic [23:0] g;
        s = 0;
        for (int j = 0; j < 8; j++) begin
            t = ((c[j] * 8 + Q / 2) / Q) % 8;
            s = s + t * (1 << (3 * j));
        end
        g[23:16] = 8'(s % 256);
        g[15:8]  = 8'((s / 256) % 256);
        g[7:0]   = 8'(s / 65536);
        return g;
    endfunction

    // Starts a group on the next edge and waits (bounded) for done.
    // Returns in the done cycle, so a following call restarts back-to-back.
    task automatic run_group(input logic [23:0] g, input bit keep_en, input string tag);
        int lat;
        int busy_cyc;
        iCiphertext_Group = g;
        enable = 1'b1;
        tick();
        if (!keep_en) enable = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (!Unpack_Group_done && lat < 20) begin
            if (busy) busy_cyc++;
            if (keep_en) iCiphertext_Group = $urandom;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 96'(lat), 96'd9);
        chk({tag, "_busy_cycles"}, 96'(busy_cyc), 96'd9);
        chk({tag, "_coeffs"}, oCoeffs, ref_group(g));
        chk({tag, "_busy_at_done"}, 96'(busy), 96'd0);
    endtask

    initial begin
        int c [8];
        int e;
        logic [23:0] g;
        logic [95:0] prev;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        iCiphertext_Group = '0;
        #2;
        chk("reset_busy", 96'(busy), 96'd0);
        chk("reset_done", 96'(Unpack_Group_done), 96'd0);
        chk("reset_coeffs", oCoeffs, 96'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        run_group(24'h000000, 1'b0, "zero");
        chk("zero_abs", oCoeffs, 96'd0);
        tick();
        run_group(24'hFFFFFF, 1'b0, "ones");
        chk("ones_abs", oCoeffs, {8{12'hB61}});
        tick();
        chk("done_one_cycle", 96'(Unpack_Group_done), 96'd0);
        run_group(24'h88C6FA, 1'b0, "ramp");
        chk("ramp_abs", oCoeffs,
            {12'd0, 12'd416, 12'd832, 12'd1248, 12'd1665, 12'd2081, 12'd2497, 12'd2913});

        // Round trip, back-to-back: each run_group returns in the done cycle
        // and the next starts on the following edge, giving a 10-clock period.
        for (int n = 0; n < 1000; n++) begin
            for (int j = 0; j < 8; j++) c[j] = int'($urandom_range(Q - 1, 0));
            if (n == 0) for (int j = 0; j < 8; j++) c[j] = (j == 0) ? Q - 1 : j * 416;
            g = pack_group(c);
            run_group(g, 1'b0, "rt");
            for (int j = 0; j < 8; j++) begin
                e = int'(oCoeffs[95 - 12*j -: 12]) - c[j];
                if (e < 0) e = -e;
                if (Q - e < e) e = Q - e;
                chk("rt_err_bound", 96'(e <= 208), 96'd1);
            end
        end
        enable = 1'b0;
        tick();

        // enable held and input scrambled during UNPACK.
        run_group(24'h5A3C96, 1'b1, "hold");
        enable = 1'b0;
        tick();
        chk("hold_no_restart", 96'(busy), 96'd0);

        // Reset asserted in the 4th UNPACK cycle.
        prev = oCoeffs;
        chk("pre_reset_nonzero", 96'(prev != 96'd0), 96'd1);
        iCiphertext_Group = 24'hFFFFFF;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy_before_rst", 96'(busy), 96'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_done", 96'(Unpack_Group_done), 96'd0);
        chk("rst_coeffs", oCoeffs, 96'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_done", 96'(Unpack_Group_done), 96'd0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_idle_done", 96'(Unpack_Group_done), 96'd0);
        end
        run_group(24'h88C6FA, 1'b0, "post_rst");

        // A few purely random groups, not from the packer.
        for (int n = 0; n < 20; n++) begin
            tick();
            run_group(24'($urandom), 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
